sdp_x_x_relu_core_chn_relu_in_rsci: RTL and testbench
=====================================================

// Module: sdp_x_x_relu_core_chn_relu_in_rsci
// PURPOSE
//  Input-channel interface of the SDP X relu core: the receive end of the relu data channel. Upstream drives the
//  valid/ready stream into a 2-entry skid FIFO. The core reads through the oswt/wen_comp/bdwt wait handshake used on
//  relu_out. A bcwt hold flag plus a hold register keep read data stable while the core stalls on another channel.
//  A saturating stall counter supports perf debug.
// PARAMETERS
//  DATA_W  512  payload width of chn_relu_in_pd / chn_relu_in_rsci_idat_mxwt
//  CNT_W   32   width of stall counter
// PORTS
//  nvdla_core_clk              in   1       core clock, all flops rise-edge
//  nvdla_core_rst              in   1       asynchronous, active-high reset
//  chn_relu_in_vld             in   1       upstream valid
//  chn_relu_in_rdy             out  1       upstream ready, registered
//  chn_relu_in_pd              in   DATA_W  upstream payload
//  chn_relu_in_rsci_oswt       in   1       core requests one read this cycle
//  chn_relu_in_rsci_bdwt       in   1       core advances this cycle (all channels satisfied)
//  chn_relu_in_rsci_wen_comp   out  1       core may proceed: ~oswt | bawt
//  chn_relu_in_rsci_bawt       out  1       read data available to core: biwt | bcwt
//  chn_relu_in_rsci_idat_mxwt  out  DATA_W  read data, valid when bawt
//  chn_relu_in_fifo_cnt        out  2       skid FIFO occupancy 0..2
//  chn_relu_in_stall_cnt       out  CNT_W   cycles with oswt & ~bawt, saturating
// BEHAVIOUR
//  Reset (async, nvdla_core_rst=1): FIFO empty, cnt=0, rdy=0, bcwt=0, hold reg=0, stall_cnt=0.
//   wen_comp=1 whenever oswt=0. rdy rises on the first clock edge after reset deasserts.
//  Push: vld & rdy. rdy_q <= (cnt_next < 2). A push never targets a full FIFO. vld with rdy=0 is not taken.
//  Upstream rule: pd is held stable while vld & ~rdy (checked by assertion, not enforced).
//  Read side:
//   biwt = oswt & ~bcwt & (cnt != 0); biwt pops the FIFO head.
//   bawt = biwt | bcwt; wen_comp = ~oswt | bawt.
//   bcwt <= bawt & ~bdwt: data is popped or held but not yet consumed, so it stays held.
//   hold_q <= FIFO head on every biwt.
//   idat_mxwt = bcwt ? hold_q : FIFO head. It is never a newer word while bcwt=1.
//   bdwt with bawt=0 has no effect on state.
//  Latency: no FIFO bypass. A word pushed at cycle N is first visible as biwt at N+1.
//   Sustained throughput is 1 word/cycle with rdy held high at cnt<=1.
//  Simultaneous push+pop: cnt unchanged, order preserved (FIFO, head = oldest).
//  Full (cnt=2): rdy=0 next cycle unless a pop occurs; a pop at cnt=2 makes rdy=1 on the following cycle.
//  Empty (cnt=0) with oswt & ~bcwt: bawt=0, wen_comp=0, stall_cnt += 1.
//  While bcwt=1, oswt stays asserted by the core; no further pop occurs until bdwt clears bcwt.
//  stall_cnt: increments on oswt & ~bawt; holds at 2^CNT_W-1; cleared only by reset.
//  Reset mid-operation: in-flight and held words are discarded and all state returns to reset values.
//   No partial-word output.
// STRUCTURE
//  Package sdp_relu_chn_pkg: DATA_W default, FIFO depth constant (2), occupancy type.
//  Sub-module sdp_relu_in_skid_fifo: 2-entry register FIFO (wr/rd pointer, cnt, registered rdy).
//  Top holds bcwt, hold_q, output mux, stall counter.
// TESTING
//  1. Reset, vld=1 pd=0xA5 at cycle 2, oswt=1 bdwt=1 -> rdy=1 cycle 1; bawt=1 and idat=0xA5 at cycle 3; cnt back to 0.
//  2. Push 0x1,0x2,0x3 back-to-back, oswt=0 -> cnt=2, rdy=0 after 2nd push, 0x3 held off;
//     then oswt=bdwt=1 -> reads 0x1,0x2,0x3 in order.
//  3. FIFO holds 0x7,0x8; oswt=1, bdwt=0 for 3 cycles then 1 -> bcwt=1, idat stays 0x7 all 4 cycles;
//     0x8 returned next; cnt=1 during stall.
//  4. oswt=1 with FIFO empty for 5 cycles -> wen_comp=0, stall_cnt=5; push 0x9 -> bawt=1 next cycle.
//  5. Assert nvdla_core_rst while cnt=2 and bcwt=1 -> all outputs reset values immediately (async).
//     Post-reset reads return only newly pushed data.
//  6. Random vld/oswt/bdwt, 10k cycles, scoreboard -> in-order, no loss or duplication, no push at cnt=2,
//     idat stable while bcwt.

Source files
------------

// File: rtl/sdp_relu_chn_pkg.sv
// Shared constants and types for the SDP relu input channel.
// Occupancy of the 2-entry skid FIFO fits in two bits (0..2).
package sdp_relu_chn_pkg;

  localparam int DATA_W_DEF = 512;
  localparam int CNT_W_DEF  = 32;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  function automatic occ_t occ_next(input occ_t cnt, input logic push, input logic pop);
    return cnt + occ_t'(push) - occ_t'(pop);
  endfunction

endpackage

// File: rtl/sdp_relu_in_skid_fifo.sv
// Two-entry register FIFO with registered ready; head is the oldest word.
// No bypass: a word written this cycle becomes readable on the next one.
module sdp_relu_in_skid_fifo
  import sdp_relu_chn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [DATA_W-1:0] wr_pd,
  input  logic              rd_pop,
  output logic [DATA_W-1:0] rd_pd,
  output occ_t              cnt
);

  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  occ_t              cnt_q;
  occ_t              cnt_nxt;
  logic              rdy_q;
  logic              push;
  logic              pop;

  assign push    = wr_vld & rdy_q;
  assign pop     = rd_pop & (cnt_q != OCC_EMPTY);
  assign cnt_nxt = occ_next(cnt_q, push, pop);

  // Depth is two, so each pointer is a single toggling bit.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= OCC_EMPTY;
      rdy_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_pd;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_nxt;
      rdy_q <= (cnt_nxt < OCC_FULL);
    end
  end

  assign wr_rdy = rdy_q;
  assign rd_pd  = mem_q[rd_ptr_q];
  assign cnt    = cnt_q;

  a_no_overflow: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    push |-> (cnt_q != OCC_FULL));

endmodule

// File: rtl/sdp_x_x_relu_core_chn_relu_in_rsci.sv
// Receive end of the relu input channel: skid FIFO feeding the core's oswt/bdwt wait handshake.
// A popped-but-unconsumed word is parked in hold_q (bcwt) so read data stays stable across core stalls.
module sdp_x_x_relu_core_chn_relu_in_rsci
  import sdp_relu_chn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              chn_relu_in_vld,
  output logic              chn_relu_in_rdy,
  input  logic [DATA_W-1:0] chn_relu_in_pd,
  input  logic              chn_relu_in_rsci_oswt,
  input  logic              chn_relu_in_rsci_bdwt,
  output logic              chn_relu_in_rsci_wen_comp,
  output logic              chn_relu_in_rsci_bawt,
  output logic [DATA_W-1:0] chn_relu_in_rsci_idat_mxwt,
  output logic [1:0]        chn_relu_in_fifo_cnt,
  output logic [CNT_W-1:0]  chn_relu_in_stall_cnt
);

  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  occ_t              fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] hold_q;
  logic              bcwt_q;
  logic              biwt;
  logic              bawt;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt_q;

  sdp_relu_in_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .wr_vld         (chn_relu_in_vld),
    .wr_rdy         (chn_relu_in_rdy),
    .wr_pd          (chn_relu_in_pd),
    .rd_pop         (biwt),
    .rd_pd          (fifo_head),
    .cnt            (fifo_cnt)
  );

  // A fresh pop is only taken when nothing is already parked in hold_q.
  assign biwt  = chn_relu_in_rsci_oswt & ~bcwt_q & (fifo_cnt != OCC_EMPTY);
  assign bawt  = biwt | bcwt_q;
  assign stall = chn_relu_in_rsci_oswt & ~bawt;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      bcwt_q <= 1'b0;
      hold_q <= '0;
    end else begin
      bcwt_q <= bawt & ~chn_relu_in_rsci_bdwt;
      if (biwt) begin
        hold_q <= fifo_head;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign chn_relu_in_rsci_bawt      = bawt;
  assign chn_relu_in_rsci_wen_comp  = ~chn_relu_in_rsci_oswt | bawt;
  assign chn_relu_in_rsci_idat_mxwt = bcwt_q ? hold_q : fifo_head;
  assign chn_relu_in_fifo_cnt       = fifo_cnt;
  assign chn_relu_in_stall_cnt      = stall_cnt_q;

  // Upstream must keep a refused payload steady; the core must keep oswt up while a word is parked.
  a_pd_hold: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    (chn_relu_in_vld && !chn_relu_in_rdy) |=> (!chn_relu_in_vld || $stable(chn_relu_in_pd)));

  a_oswt_held: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    bcwt_q |-> chn_relu_in_rsci_oswt);

endmodule

// File: tb/tb_sdp_x_x_relu_core_chn_relu_in_rsci.sv
// Scoreboard bench for the relu input channel: directed scenarios plus a constrained random run.
module tb_sdp_x_x_relu_core_chn_relu_in_rsci;

  localparam int CW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic          rdy;
  logic [CW-1:0] pd = '0;
  logic          oswt = 1'b0;
  logic          bdwt = 1'b0;
  logic          wen_comp;
  logic          bawt;
  logic [CW-1:0] idat;
  logic [1:0]    fifo_cnt;
  logic [31:0]   stall_cnt;

  int errs = 0;
  int checks = 0;

  logic [CW-1:0] q[$];
  logic          exp_bcwt = 1'b0;
  logic          exp_rdy = 1'b0;
  logic [31:0]   exp_stall = '0;

  always #5 clk = ~clk;

  sdp_x_x_relu_core_chn_relu_in_rsci #(
    .DATA_W (CW),
    .CNT_W  (32)
  ) dut (
    .nvdla_core_clk             (clk),
    .nvdla_core_rst             (rst),
    .chn_relu_in_vld            (vld),
    .chn_relu_in_rdy            (rdy),
    .chn_relu_in_pd             (pd),
    .chn_relu_in_rsci_oswt      (oswt),
    .chn_relu_in_rsci_bdwt      (bdwt),
    .chn_relu_in_rsci_wen_comp  (wen_comp),
    .chn_relu_in_rsci_bawt      (bawt),
    .chn_relu_in_rsci_idat_mxwt (idat),
    .chn_relu_in_fifo_cnt       (fifo_cnt),
    .chn_relu_in_stall_cnt      (stall_cnt)
  );

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: the queue holds every accepted word not yet consumed (FIFO contents plus the parked word).
  always @(negedge clk) begin
    int  occ;
    logic eb;
    if (rst) begin
      q.delete();
      exp_bcwt  = 1'b0;
      exp_rdy   = 1'b0;
      exp_stall = '0;
    end else begin
      eb  = oswt && (q.size() != 0);
      occ = q.size() - (exp_bcwt ? 1 : 0);
      check("mon_bawt", CW'(bawt), CW'(eb));
      check("mon_wen_comp", CW'(wen_comp), CW'(!oswt || eb));
      check("mon_fifo_cnt", CW'(fifo_cnt), CW'(occ));
      check("mon_rdy", CW'(rdy), CW'(exp_rdy));
      check("mon_stall_cnt", CW'(stall_cnt), CW'(exp_stall));
      if (eb) check("mon_idat", idat, q[0]);
      if (oswt && !eb && exp_stall != '1) exp_stall = exp_stall + 32'd1;
      if (eb && bdwt) void'(q.pop_front());
      if (vld && exp_rdy) begin
        check("mon_push_not_full", CW'(fifo_cnt != 2'd2), CW'(1));
        q.push_back(pd);
      end
      exp_bcwt = eb && !bdwt;
      exp_rdy  = ((q.size() - (exp_bcwt ? 1 : 0)) < 2);
    end
  end

  task automatic do_reset();
    rst  = 1'b1;
    vld  = 1'b0;
    oswt = 1'b0;
    bdwt = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    logic keep_rd;
    int   seq;

    // 1: first word after reset
    do_reset();
    oswt = 1'b1; bdwt = 1'b1;
    mid(); check("t1_rdy_c0", CW'(rdy), CW'(0)); check("t1_wen_c0", CW'(wen_comp), CW'(0));
    cyc();
    mid(); check("t1_rdy_c1", CW'(rdy), CW'(1));
    cyc();
    vld = 1'b1; pd = CW'(32'hA5);
    mid(); cyc();
    vld = 1'b0;
    mid(); check("t1_bawt_c3", CW'(bawt), CW'(1)); check("t1_idat_c3", idat, CW'(32'hA5));
    check("t1_cnt_c3", CW'(fifo_cnt), CW'(1));
    cyc();
    oswt = 1'b0; bdwt = 1'b0;
    mid(); check("t1_cnt_c4", CW'(fifo_cnt), CW'(0));
    cyc();

    // 2: fill to full, third word held off, then drain in order
    vld = 1'b1; pd = CW'(1);
    mid(); cyc();
    pd = CW'(2);
    mid(); cyc();
    pd = CW'(3);
    mid(); check("t2_cnt_full", CW'(fifo_cnt), CW'(2)); check("t2_rdy_full", CW'(rdy), CW'(0));
    cyc();
    mid(); check("t2_rdy_held", CW'(rdy), CW'(0)); check("t2_cnt_held", CW'(fifo_cnt), CW'(2));
    cyc();
    oswt = 1'b1; bdwt = 1'b1;
    mid(); check("t2_idat_1", idat, CW'(1)); check("t2_rdy_pop", CW'(rdy), CW'(0));
    cyc();
    mid(); check("t2_idat_2", idat, CW'(2)); check("t2_rdy_after_pop", CW'(rdy), CW'(1));
    cyc();
    vld = 1'b0;
    mid(); check("t2_idat_3", idat, CW'(3)); check("t2_cnt_last", CW'(fifo_cnt), CW'(1));
    cyc();
    oswt = 1'b0; bdwt = 1'b0;
    mid(); check("t2_cnt_empty", CW'(fifo_cnt), CW'(0));
    cyc();

    // 3: core stall with a parked word
    vld = 1'b1; pd = CW'(7);
    mid(); cyc();
    pd = CW'(8);
    mid(); cyc();
    vld = 1'b0; oswt = 1'b1; bdwt = 1'b0;
    mid(); check("t3_idat_s0", idat, CW'(7)); check("t3_cnt_s0", CW'(fifo_cnt), CW'(2));
    cyc();
    for (int i = 1; i <= 2; i++) begin
      mid(); check("t3_idat_stall", idat, CW'(7)); check("t3_cnt_stall", CW'(fifo_cnt), CW'(1));
      check("t3_bawt_stall", CW'(bawt), CW'(1));
      cyc();
    end
    bdwt = 1'b1;
    mid(); check("t3_idat_s3", idat, CW'(7)); check("t3_bawt_s3", CW'(bawt), CW'(1));
    cyc();
    mid(); check("t3_idat_next", idat, CW'(8)); check("t3_bawt_next", CW'(bawt), CW'(1));
    cyc();
    oswt = 1'b0; bdwt = 1'b0;
    mid(); check("t3_cnt_end", CW'(fifo_cnt), CW'(0));
    cyc();

    // 4: read from empty FIFO accumulates stall cycles
    do_reset();
    mid(); cyc();
    oswt = 1'b1; bdwt = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin vld = 1'b1; pd = CW'(9); end
      mid(); check("t4_wen_empty", CW'(wen_comp), CW'(0));
      cyc();
    end
    vld = 1'b0;
    mid(); check("t4_stall_5", CW'(stall_cnt), CW'(5)); check("t4_bawt", CW'(bawt), CW'(1));
    check("t4_idat", idat, CW'(9));
    cyc();
    oswt = 1'b0; bdwt = 1'b0;
    mid(); check("t4_stall_hold", CW'(stall_cnt), CW'(5));
    cyc();

    // 5: asynchronous reset with FIFO full and a word parked
    vld = 1'b1; pd = CW'(32'h11);
    mid(); cyc();
    pd = CW'(32'h22);
    mid(); cyc();
    pd = CW'(32'h33); oswt = 1'b1; bdwt = 1'b0;
    mid(); cyc();
    mid(); cyc();
    vld = 1'b0;
    mid(); check("t5_cnt_pre", CW'(fifo_cnt), CW'(2)); check("t5_bawt_pre", CW'(bawt), CW'(1));
    check("t5_idat_pre", idat, CW'(32'h11));
    #1;
    rst = 1'b1; oswt = 1'b0;
    #1;
    check("t5_rst_rdy", CW'(rdy), CW'(0)); check("t5_rst_cnt", CW'(fifo_cnt), CW'(0));
    check("t5_rst_idat", idat, CW'(0)); check("t5_rst_stall", CW'(stall_cnt), CW'(0));
    check("t5_rst_wen", CW'(wen_comp), CW'(1));
    oswt = 1'b1; #1;
    check("t5_rst_bawt", CW'(bawt), CW'(0));
    oswt = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    mid(); check("t5_rdy_c0", CW'(rdy), CW'(0));
    cyc();
    vld = 1'b1; pd = CW'(32'h44);
    mid(); cyc();
    vld = 1'b0; oswt = 1'b1; bdwt = 1'b1;
    mid(); check("t5_idat_new", idat, CW'(32'h44));
    cyc();
    oswt = 1'b0; bdwt = 1'b0;

    // 6: random traffic checked by the monitor
    seq = 100;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      acc     = vld && rdy;
      keep_rd = oswt && bawt && !bdwt;
      @(posedge clk);
      #1;
      if (!(vld && !acc)) begin
        vld = ($urandom_range(0, 3) != 0);
        seq++;
        pd  = CW'(seq) | (CW'($urandom) << 480);
      end
      oswt = keep_rd ? 1'b1 : ($urandom_range(0, 3) != 0);
      bdwt = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    vld = 1'b0; oswt = 1'b1; bdwt = 1'b1;
    repeat (6) begin mid(); cyc(); end
    mid(); check("t6_drain_cnt", CW'(fifo_cnt), CW'(0)); check("t6_drain_bawt", CW'(bawt), CW'(0));
    cyc();
    oswt = 1'b0; bdwt = 1'b0;
    mid();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
